// File: rtl/prot_cfg_pkg.sv
// rtl/prot_cfg_pkg.sv - response codes, field map and helpers for the region config slave
// Optional lock word location LOCK_OFFSET is only decoded when PROT_CFG_LOCK_EN is defined.
package prot_cfg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    FLD_BASE  = 2'd0,
    FLD_LIMIT = 2'd1,
    FLD_PERM  = 2'd2,
    FLD_TAG   = 2'd3
  } fld_e;

  localparam int PERM_RD_BIT = 0;
  localparam int PERM_WR_BIT = 1;

  localparam logic [31:0] LOCK_OFFSET = 32'h0000_0100;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/prot_cfg_regfile.sv
// rtl/prot_cfg_regfile.sv - per-region BASE/LIMIT/PERM/TAG storage with byte-strobed write
// One write port (merged with the current word) and one combinational read port.
module prot_cfg_regfile
  import prot_cfg_pkg::*;
#(
  parameter int N_REGIONS = 4,
  parameter int RIDX_W    = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [RIDX_W-1:0]       wr_region_i,
  input  fld_e                    wr_field_i,
  input  logic [31:0]             wdata_i,
  input  logic [3:0]              wstrb_i,
  input  logic [RIDX_W-1:0]       rd_region_i,
  input  fld_e                    rd_field_i,
  output logic [31:0]             rd_data_o,
  output logic [32*N_REGIONS-1:0] region_base_o,
  output logic [32*N_REGIONS-1:0] region_limit_o,
  output logic [2*N_REGIONS-1:0]  region_perm_o
);

  logic [31:0] base_q  [N_REGIONS];
  logic [31:0] limit_q [N_REGIONS];
  logic [1:0]  perm_q  [N_REGIONS];
  logic [31:0] tag_q   [N_REGIONS];
  logic [31:0] wr_old;
  logic [31:0] wr_new;

  function automatic logic [31:0] word_at(input logic [RIDX_W-1:0] r, input fld_e f);
    logic [31:0] v;
    v = 32'h0;
    if (int'(r) < N_REGIONS) begin
      case (f)
        FLD_BASE:  v = base_q[r];
        FLD_LIMIT: v = limit_q[r];
        FLD_PERM:  v = {30'h0, perm_q[r]};
        default:   v = tag_q[r];
      endcase
    end
    return v;
  endfunction

  always_comb begin
    wr_old = word_at(wr_region_i, wr_field_i);
    wr_new = apply_wstrb(wr_old, wdata_i, wstrb_i);
  end

  assign rd_data_o = word_at(rd_region_i, rd_field_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_REGIONS; r++) begin
        base_q[r]  <= '0;
        limit_q[r] <= '0;
        perm_q[r]  <= '0;
        tag_q[r]   <= '0;
      end
    end else if (we_i) begin
      case (wr_field_i)
        FLD_BASE:  base_q[wr_region_i]  <= wr_new;
        FLD_LIMIT: limit_q[wr_region_i] <= wr_new;
        FLD_PERM:  perm_q[wr_region_i]  <= wr_new[1:0];
        default:   tag_q[wr_region_i]   <= wr_new;
      endcase
    end
  end

  always_comb begin
    region_base_o  = '0;
    region_limit_o = '0;
    region_perm_o  = '0;
    for (int r = 0; r < N_REGIONS; r++) begin
      region_base_o[32*r +: 32]             = base_q[r];
      region_limit_o[32*r +: 32]            = limit_q[r];
      region_perm_o[2*r + PERM_RD_BIT]      = perm_q[r][PERM_RD_BIT];
      region_perm_o[2*r + PERM_WR_BIT]      = perm_q[r][PERM_WR_BIT];
    end
  end

endmodule

// File: rtl/prot_cfg_axil_slave.sv
// rtl/prot_cfg_axil_slave.sv - AXI4-Lite responder for protection region configuration
// Define PROT_CFG_LOCK_EN to add the set-only LOCK word at byte offset 0x100.
module prot_cfg_axil_slave
  import prot_cfg_pkg::*;
#(
  parameter int N_REGIONS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_W-1:0]       S_AWADDR,
  input  logic [2:0]              S_AWPROT,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_W-1:0]       S_WDATA,
  input  logic [3:0]              S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDR_W-1:0]       S_ARADDR,
  input  logic [2:0]              S_ARPROT,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_W-1:0]       S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY,
  output logic [32*N_REGIONS-1:0] REGION_BASE,
  output logic [32*N_REGIONS-1:0] REGION_LIMIT,
  output logic [2*N_REGIONS-1:0]  REGION_PERM,
  output logic                    CFG_UPDATE
);

  localparam int RIDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  logic              aw_held_q, w_held_q, bvalid_q, rvalid_q, cfg_update_q;
  logic [ADDR_W-3:0] aw_idx_q;
  logic [31:0]       w_data_q, rdata_q, rdata_d, rf_rd_data;
  logic [3:0]        w_strb_q;
  logic [1:0]        bresp_q, rresp_q, rresp_d, wr_resp;
  logic [ADDR_W-3:0] ar_idx;
  logic              commit, reg_we;
  logic              unused_ok;

  // Word index -> region is idx>>2; anything past the last region decodes as DECERR.
  function automatic logic in_range(input logic [ADDR_W-3:0] idx);
    return 32'(idx[ADDR_W-3:2]) < N_REGIONS;
  endfunction

`ifdef PROT_CFG_LOCK_EN
  logic lock_q, lock_set;

  function automatic logic is_lock(input logic [ADDR_W-3:0] idx);
    return 32'(idx) == (LOCK_OFFSET >> 2);
  endfunction

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)        lock_q <= 1'b0;
    else if (lock_set) lock_q <= 1'b1;
  end
`endif

  assign unused_ok = ^{S_AWPROT, S_ARPROT, S_AWADDR[1:0], S_ARADDR[1:0]};
  assign ar_idx    = S_ARADDR[ADDR_W-1:2];
  assign commit    = aw_held_q && w_held_q;

  assign S_AWREADY  = !ARESET && !aw_held_q && !bvalid_q;
  assign S_WREADY   = !ARESET && !w_held_q && !bvalid_q;
  assign S_ARREADY  = !ARESET && !rvalid_q;
  assign S_BVALID   = bvalid_q;
  assign S_BRESP    = bresp_q;
  assign S_RVALID   = rvalid_q;
  assign S_RDATA    = rdata_q;
  assign S_RRESP    = rresp_q;
  assign CFG_UPDATE = cfg_update_q;

  always_comb begin
    wr_resp = RESP_DECERR;
    reg_we  = 1'b0;
`ifdef PROT_CFG_LOCK_EN
    lock_set = 1'b0;
    if (in_range(aw_idx_q)) begin
      if (lock_q) begin
        wr_resp = RESP_SLVERR;
      end else begin
        wr_resp = RESP_OKAY;
        reg_we  = commit;
      end
    end else if (is_lock(aw_idx_q)) begin
      wr_resp  = RESP_OKAY;
      lock_set = commit && w_strb_q[0] && w_data_q[0];
    end
`else
    if (in_range(aw_idx_q)) begin
      wr_resp = RESP_OKAY;
      reg_we  = commit;
    end
`endif
  end

  always_comb begin
    rdata_d = 32'h0;
    rresp_d = RESP_DECERR;
    if (in_range(ar_idx)) begin
      rdata_d = rf_rd_data;
      rresp_d = RESP_OKAY;
    end
`ifdef PROT_CFG_LOCK_EN
    else if (is_lock(ar_idx)) begin
      rdata_d = {31'h0, lock_q};
      rresp_d = RESP_OKAY;
    end
`endif
  end

  // AW and W park independently; the write retires on the edge after both are parked.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      cfg_update_q <= 1'b0;
    end else begin
      cfg_update_q <= 1'b0;
      if (S_AWVALID && S_AWREADY) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= S_AWADDR[ADDR_W-1:2];
      end
      if (S_WVALID && S_WREADY) begin
        w_held_q <= 1'b1;
        w_data_q <= S_WDATA[31:0];
        w_strb_q <= S_WSTRB;
      end
      if (commit) begin
        aw_held_q    <= 1'b0;
        w_held_q     <= 1'b0;
        bvalid_q     <= 1'b1;
        bresp_q      <= wr_resp;
        cfg_update_q <= (wr_resp == RESP_OKAY);
      end else if (bvalid_q && S_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (S_ARVALID && S_ARREADY) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (rvalid_q && S_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  prot_cfg_regfile #(
    .N_REGIONS (N_REGIONS),
    .RIDX_W    (RIDX_W)
  ) u_regfile (
    .clk            (ACLK),
    .rst            (ARESET),
    .we_i           (reg_we),
    .wr_region_i    (aw_idx_q[RIDX_W+1:2]),
    .wr_field_i     (fld_e'(aw_idx_q[1:0])),
    .wdata_i        (w_data_q),
    .wstrb_i        (w_strb_q),
    .rd_region_i    (ar_idx[RIDX_W+1:2]),
    .rd_field_i     (fld_e'(ar_idx[1:0])),
    .rd_data_o      (rf_rd_data),
    .region_base_o  (REGION_BASE),
    .region_limit_o (REGION_LIMIT),
    .region_perm_o  (REGION_PERM)
  );

endmodule

// File: tb/tb_prot_cfg_axil_slave.sv
// tb/tb_prot_cfg_axil_slave.sv - self-checking bench for prot_cfg_axil_slave
// Define PROT_CFG_LOCK_EN to also exercise the lock word.
`timescale 1ns/1ps
module tb_prot_cfg_axil_slave;

  localparam int N_REGIONS = 4;
`ifdef PROT_CFG_LOCK_EN
  localparam int ADDR_W = 9;
`else
  localparam int ADDR_W = 8;
`endif
  localparam int N_WORDS = N_REGIONS * 4;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [ADDR_W-1:0] S_AWADDR = '0, S_ARADDR = '0;
  logic [2:0] S_AWPROT = 3'b010, S_ARPROT = 3'b001;
  logic S_AWVALID = 0, S_WVALID = 0, S_BREADY = 0, S_ARVALID = 0, S_RREADY = 0;
  logic [31:0] S_WDATA = '0;
  logic [3:0] S_WSTRB = '0;
  logic S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, CFG_UPDATE;
  logic [1:0] S_BRESP, S_RRESP;
  logic [31:0] S_RDATA;
  logic [32*N_REGIONS-1:0] REGION_BASE, REGION_LIMIT;
  logic [2*N_REGIONS-1:0] REGION_PERM;

  prot_cfg_axil_slave #(.N_REGIONS(N_REGIONS), .ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .REGION_BASE(REGION_BASE), .REGION_LIMIT(REGION_LIMIT), .REGION_PERM(REGION_PERM),
    .CFG_UPDATE(CFG_UPDATE)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_fail = 0;
  int cfg_cnt = 0;
  always @(posedge ACLK) if (CFG_UPDATE === 1'b1) cfg_cnt <= cfg_cnt + 1;

  // Reference model: flat word array, PERM words keep only their two low bits.
  logic [31:0] mdl_mem [N_WORDS];
  int mdl_cfg = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  task automatic mdl_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int w;
    w = int'(addr >> 2);
    if (w >= N_WORDS) begin
      resp = 2'b11;
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl_mem[w][8*b +: 8] = d[8*b +: 8];
      if (w % 4 == 2) mdl_mem[w] = mdl_mem[w] & 32'h3;
      mdl_cfg++;
      resp = 2'b00;
    end
  endtask

  task automatic mdl_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp);
    int w;
    w = int'(addr >> 2);
    if (w >= N_WORDS) begin d = 32'h0; resp = 2'b11; end
    else begin d = mdl_mem[w]; resp = 2'b00; end
  endtask

  task automatic chk_outputs(input string nm);
    for (int r = 0; r < N_REGIONS; r++) begin
      chk($sformatf("%s_base%0d", nm, r), REGION_BASE[32*r +: 32], mdl_mem[4*r]);
      chk($sformatf("%s_limit%0d", nm, r), REGION_LIMIT[32*r +: 32], mdl_mem[4*r+1]);
      chk($sformatf("%s_perm%0d", nm, r), {30'h0, REGION_PERM[2*r +: 2]}, mdl_mem[4*r+2]);
    end
  endtask

  task automatic start_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    S_AWADDR = addr[ADDR_W-1:0]; S_WDATA = data; S_WSTRB = strb;
    S_AWVALID = 1; S_WVALID = 1;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge ACLK);
      aw_hs = S_AWVALID && S_AWREADY;
      w_hs  = S_WVALID && S_WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin S_AWVALID = 0; aw_done = 1; end
      if (w_hs)  begin S_WVALID = 0;  w_done = 1;  end
      n++;
    end
    if (!(aw_done && w_done)) begin timeout("aw_w_accept"); S_AWVALID = 0; S_WVALID = 0; end
  endtask

  task automatic wait_bvalid();
    int n;
    n = 0;
    @(negedge ACLK);
    while (S_BVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (S_BVALID !== 1'b1) timeout("bvalid");
  endtask

  task automatic wait_b(output logic [1:0] resp);
    wait_bvalid();
    resp = S_BRESP;
    S_BREADY = 1;
    @(posedge ACLK); #1;
    S_BREADY = 0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    start_write(addr, data, strb);
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int n;
    hs = 0; n = 0;
    S_ARADDR = addr[ADDR_W-1:0]; S_ARVALID = 1;
    while (!hs && n < 50) begin
      @(negedge ACLK); hs = S_ARREADY;
      @(posedge ACLK); #1;
      n++;
    end
    S_ARVALID = 0;
    if (!hs) timeout("arready");
    n = 0;
    @(negedge ACLK);
    while (S_RVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (S_RVALID !== 1'b1) timeout("rvalid");
    data = S_RDATA; resp = S_RRESP;
    S_RREADY = 1;
    @(posedge ACLK); #1;
    S_RREADY = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    bit          chk_out;
  } vec_t;

  initial begin #300000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    vec_t tbl[16];
    logic [31:0] rd, ed;
    logic [1:0] rs, es;
    int tbl_ok_writes, cfg0;

    for (int i = 0; i < N_WORDS; i++) mdl_mem[i] = 32'h0;
    tbl[0]  = '{1, 32'h00, 32'h1, 4'hF, 32'h0, 2'b00, 0};
    tbl[1]  = '{1, 32'h04, 32'h2, 4'hF, 32'h0, 2'b00, 0};
    tbl[2]  = '{1, 32'h08, 32'h3, 4'hF, 32'h0, 2'b00, 0};
    tbl[3]  = '{1, 32'h0C, 32'h4, 4'hF, 32'h0, 2'b00, 0};
    tbl[4]  = '{0, 32'h00, 32'h0, 4'h0, 32'h1, 2'b00, 0};
    tbl[5]  = '{0, 32'h04, 32'h0, 4'h0, 32'h2, 2'b00, 0};
    tbl[6]  = '{0, 32'h08, 32'h0, 4'h0, 32'h3, 2'b00, 0};
    tbl[7]  = '{0, 32'h0C, 32'h0, 4'h0, 32'h4, 2'b00, 1};
    tbl[8]  = '{0, 32'h40, 32'h0, 4'h0, 32'h0, 2'b11, 0};
    tbl[9]  = '{1, 32'h44, 32'h12345678, 4'hF, 32'h0, 2'b11, 1};
    tbl[10] = '{1, 32'h0A, 32'hFFFFFFFD, 4'h1, 32'h0, 2'b00, 0};
    tbl[11] = '{0, 32'h09, 32'h0, 4'h0, 32'h1, 2'b00, 0};
    tbl[12] = '{1, 32'h04, 32'hAABBCCDD, 4'h4, 32'h0, 2'b00, 0};
    tbl[13] = '{0, 32'h07, 32'h0, 4'h0, 32'h00BB0002, 2'b00, 0};
    tbl[14] = '{1, 32'h00, 32'hFFFFFFFF, 4'h0, 32'h0, 2'b00, 0};
    tbl[15] = '{0, 32'h03, 32'h0, 4'h0, 32'h1, 2'b00, 0};

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", S_AWREADY, 0); chk("rst_wready", S_WREADY, 0);
    chk("rst_arready", S_ARREADY, 0); chk("rst_bvalid", S_BVALID, 0);
    chk("rst_rvalid", S_RVALID, 0); chk("rst_rdata", S_RDATA, 0);
    chk("rst_bresp", S_BRESP, 0); chk("rst_rresp", S_RRESP, 0);
    chk("rst_cfg", CFG_UPDATE, 0);
    chk_outputs("rst");
    @(negedge ACLK); ARESET = 0;
    @(posedge ACLK); #1;
    chk("post_rst_awready", S_AWREADY, 1);

    tbl_ok_writes = 0;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, rs);
        mdl_write(tbl[i].addr, tbl[i].data, tbl[i].strb, es);
        chk($sformatf("tbl%0d_bresp", i), rs, tbl[i].exp_resp);
        if (tbl[i].exp_resp == 2'b00) tbl_ok_writes++;
      end else begin
        axi_read(tbl[i].addr, rd, rs);
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_data);
        chk($sformatf("tbl%0d_rresp", i), rs, tbl[i].exp_resp);
      end
      if (tbl[i].chk_out) begin
        chk($sformatf("tbl%0d_base0", i), REGION_BASE[31:0], 32'h1);
        chk($sformatf("tbl%0d_limit0", i), REGION_LIMIT[31:0], 32'h2);
        chk($sformatf("tbl%0d_perm0", i), {30'h0, REGION_PERM[1:0]}, 32'h3);
        chk($sformatf("tbl%0d_cfg", i), cfg_cnt, 4);
      end
    end
    chk("tbl_cfg_count", cfg_cnt, tbl_ok_writes);
    chk_outputs("tbl");

    // W arrives three cycles ahead of AW
    cfg0 = cfg_cnt;
    S_WDATA = 32'hDEADBEEF; S_WSTRB = 4'b0011; S_WVALID = 1;
    @(negedge ACLK); chk("early_w_wready", S_WREADY, 1);
    @(posedge ACLK); #1; S_WVALID = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK); chk($sformatf("early_w_no_b%0d", c), S_BVALID, 0);
      @(posedge ACLK); #1;
    end
    S_AWADDR = 8'h1C; S_AWVALID = 1;
    @(negedge ACLK); chk("early_w_awready", S_AWREADY, 1);
    @(posedge ACLK); #1; S_AWVALID = 0;
    wait_b(rs);
    mdl_write(32'h1C, 32'hDEADBEEF, 4'b0011, es);
    chk("early_w_bresp", rs, 2'b00);
    chk("early_w_cfg", cfg_cnt, cfg0 + 1);
    axi_read(32'h1C, rd, rs);
    chk("early_w_rdata", rd, 32'h0000BEEF);

    // Back-pressure on B blocks any further AW/W
    start_write(32'h10, 32'hA5A5A5A5, 4'hF);
    mdl_write(32'h10, 32'hA5A5A5A5, 4'hF, es);
    wait_bvalid();
    S_AWADDR = 8'h14; S_AWVALID = 1; S_WDATA = 32'h5A5A5A5A; S_WSTRB = 4'hF; S_WVALID = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      chk($sformatf("bp_bvalid%0d", c), S_BVALID, 1);
      chk($sformatf("bp_awready%0d", c), S_AWREADY, 0);
      chk($sformatf("bp_wready%0d", c), S_WREADY, 0);
    end
    S_BREADY = 1;
    @(posedge ACLK); #1; S_BREADY = 0;
    @(negedge ACLK); chk("bp_awready_after", S_AWREADY, 1); chk("bp_bvalid_after", S_BVALID, 0);
    @(posedge ACLK); #1; S_AWVALID = 0; S_WVALID = 0;
    wait_b(rs);
    mdl_write(32'h14, 32'h5A5A5A5A, 4'hF, es);
    chk("bp_second_bresp", rs, 2'b00);
    axi_read(32'h10, rd, rs); mdl_read(32'h10, ed, es); chk("bp_rd10", rd, ed);
    axi_read(32'h14, rd, rs); mdl_read(32'h14, ed, es); chk("bp_rd14", rd, ed);

    // Same-edge commit and read of 0x0C
    S_AWADDR = 8'h0C; S_WDATA = 32'h55; S_WSTRB = 4'hF; S_AWVALID = 1; S_WVALID = 1;
    @(negedge ACLK); chk("coll_ready", {S_AWREADY, S_WREADY}, 2'b11);
    @(posedge ACLK); #1; S_AWVALID = 0; S_WVALID = 0; S_ARADDR = 8'h0C; S_ARVALID = 1;
    @(negedge ACLK); chk("coll_arready", S_ARREADY, 1);
    @(posedge ACLK); #1; S_ARVALID = 0;
    @(negedge ACLK);
    chk("coll_bvalid", S_BVALID, 1); chk("coll_rvalid", S_RVALID, 1);
    chk("coll_old_data", S_RDATA, 32'h4);
    S_RREADY = 1; S_BREADY = 1;
    @(posedge ACLK); #1; S_RREADY = 0; S_BREADY = 0;
    mdl_write(32'h0C, 32'h55, 4'hF, es);
    axi_read(32'h0C, rd, rs);
    chk("coll_new_data", rd, 32'h55);

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, d;
      logic [3:0] s;
      a = 32'($urandom_range(0, N_WORDS + 3)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, s, rs);
        mdl_write(a, d, s, es);
        chk($sformatf("rnd%0d_bresp@%h", i, a), rs, es);
      end else begin
        axi_read(a, rd, rs);
        mdl_read(a, ed, es);
        chk($sformatf("rnd%0d_rdata@%h", i, a), rd, ed);
        chk($sformatf("rnd%0d_rresp@%h", i, a), rs, es);
      end
    end
    chk_outputs("rnd");
    chk("rnd_cfg_count", cfg_cnt, mdl_cfg);

`ifdef PROT_CFG_LOCK_EN
    axi_read(32'h100, rd, rs);
    chk("lock_rd0", rd, 0); chk("lock_rd0_resp", rs, 2'b00);
    axi_write(32'h100, 32'h1, 4'hF, rs);
    mdl_cfg++;
    chk("lock_set_resp", rs, 2'b00);
    axi_write(32'h00, 32'hCAFEF00D, 4'hF, rs);
    chk("locked_wr_resp", rs, 2'b10);
    axi_read(32'h00, rd, rs);
    chk("locked_wr_unchanged", rd, mdl_mem[0]);
    axi_read(32'h100, rd, rs);
    chk("lock_rd1", rd, 1); chk("lock_rd1_resp", rs, 2'b00);
    chk("lock_cfg_count", cfg_cnt, mdl_cfg);
`endif

    // Reset with both a B and an R response pending
    start_write(32'h20, 32'h12345678, 4'hF);
    wait_bvalid();
    S_ARADDR = 8'h00; S_ARVALID = 1;
    @(posedge ACLK); #1; S_ARVALID = 0;
    @(negedge ACLK);
    chk("pre_rst_bvalid", S_BVALID, 1); chk("pre_rst_rvalid", S_RVALID, 1);
    #2 ARESET = 1;
    #1;
    chk("arst_bvalid", S_BVALID, 0); chk("arst_rvalid", S_RVALID, 0);
    chk("arst_rdata", S_RDATA, 0); chk("arst_awready", S_AWREADY, 0);
    @(negedge ACLK); ARESET = 0;
    for (int i = 0; i < N_WORDS; i++) mdl_mem[i] = 32'h0;
    @(posedge ACLK); #1;
    chk_outputs("arst");
    for (int w = 0; w < N_WORDS; w++) begin
      axi_read(32'(w * 4), rd, rs);
      chk($sformatf("arst_rd%0d", w), rd, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
